sqrt_sched: RTL and testbench
=============================

SQRT_SCHED -- requirements
Module: sqrt_sched

Interface
REQ-001 Parameters SHALL be:
  NREQ, 2, number of requesters (2..4)
  TIMEOUT, 15, max cycles waiting for it_result before abort (4..255)
REQ-002 Ports SHALL be (clock and reset first):
  clk  in  1  single clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  req_valid  in  NREQ  per-requester operand valid
  req_op  in  NREQ*23  per-requester {nan,pinf,ninf,num,sign,exp[6:0],mant[10:0]}
  req_ready  out  NREQ  one-hot, 1-cycle operand accept
  rsp_valid  out  1  result valid, held until rsp_ready
  rsp_ready  in  1  result consumer accept
  rsp_id  out  2  index of requester owning the result
  rsp_data  out  19  {sign,exp[6:0],mant[10:0]}
  rsp_flags  out  4  {nan,pinf,ninf,timeout}
  it_enable  out  1  sqrt unit enable (low = unit clear)
  it_n_valid  out  1  sqrt unit operand strobe
  it_op  out  23  operand to unit, same packing as req_op
  it_valid  in  1  unit step valid (ignored except for debug)
  it_result  in  1  unit final-result strobe
  it_res  in  19  unit {sign_out,exp_out,mant_out}
  it_flags  in  3  unit {is_nan_out,is_pinf_out,is_ninf_out}

Function
REQ-003 FSM SHALL have states IDLE, ISSUE, BUSY, RESP, FLUSH; exactly one operation in flight.
REQ-004 IDLE: if any req_valid, grant round-robin starting at (last_grant+1) mod NREQ; assert req_ready[g] that cycle, capture req_op[g] and g; go ISSUE.
REQ-005 Simultaneous requests: lowest index at or after pointer wins; pointer updates only on grant.
REQ-006 ISSUE: it_n_valid=1 for exactly one cycle with captured operand on it_op; go BUSY; it_op held stable until RESP.
REQ-007 BUSY: on it_result=1 capture it_res/it_flags, timeout flag=0, go RESP; it_result in same cycle as timeout expiry SHALL win.
REQ-008 RESP: rsp_valid=1, rsp_data/rsp_flags/rsp_id stable; on rsp_valid&&rsp_ready go IDLE (new grant earliest next cycle).
REQ-009 No req_ready SHALL assert outside IDLE; it_result outside BUSY SHALL be ignored.
REQ-010 it_enable SHALL be 1 in all states except FLUSH.
REQ-011 Timeout counter: 8 bits, cleared on ISSUE, increments each BUSY cycle, saturates.

Reset
REQ-012 rst_n low SHALL asynchronously force: state IDLE, pointer to NREQ-1 (requester 0 first), req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_flags=0, it_n_valid=0, it_op=0, it_enable=0.
REQ-013 it_enable SHALL rise on the first clk edge after rst_n deassertion; mid-operation reset discards the operation, no response.

Configuration
REQ-014 SQRT_SCHED_TIMEOUT_EN defined: counter reaching TIMEOUT in BUSY -> FLUSH (it_enable=0 one cycle) -> RESP with rsp_data=0, rsp_flags=4'b0001.
REQ-015 SQRT_SCHED_TIMEOUT_EN undefined: no counter logic, BUSY waits indefinitely, rsp_flags[0] tied 0, FLUSH unreachable.

Structure
REQ-016 Shared package sqrt_pkg SHALL hold operand/result widths (23, 19), flag bit positions, FSM state encoding and the NaN constant {1,16,11'b10000000000}.
REQ-017 One sub-module rr_arbiter (NREQ req in, one-hot grant out, pointer update input) SHALL implement REQ-004/005.

Verification
REQ-018 Requester 0 sends 4.0 (exp=2, mant=0) with real unit -> req_ready[0] same cycle, it_n_valid next, rsp_data exp=1 mant=0, rsp_id=0.
REQ-019 Both requesters valid continuously, 4 ops -> grant order 0,1,0,1; no back-to-back double grant.
REQ-020 Operand with ninf=1 -> it_result one cycle after it_n_valid; rsp_flags=4'b1000, rsp_data sign=1 exp=16 mant=11'b10000000000.
REQ-021 rsp_ready held low 10 cycles -> rsp_valid and data stable, req_ready stays 0 throughout.
REQ-022 Stub unit never strobes, macro defined, TIMEOUT=15 -> it_enable low exactly one cycle after 15 BUSY cycles, rsp_flags=4'b0001.
REQ-023 rst_n pulsed low during BUSY -> outputs at reset values immediately, no rsp_valid after release.

Source files
------------

// File: rtl/sqrt_pkg.sv
// Shared widths, flag positions, FSM encoding and the canonical NaN result
// for the sqrt scheduler.
package sqrt_pkg;

   localparam int OP_W  = 23;
   localparam int RES_W = 19;
   localparam int FLG_W = 4;

   localparam int OP_NAN  = 22;
   localparam int OP_PINF = 21;
   localparam int OP_NINF = 20;
   localparam int OP_NUM  = 19;

   localparam int FLG_NAN     = 3;
   localparam int FLG_PINF    = 2;
   localparam int FLG_NINF    = 1;
   localparam int FLG_TIMEOUT = 0;

   localparam logic [RES_W-1:0] NAN_RES = {1'b1, 7'd16, 11'b10000000000};

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      BUSY  = 3'd2,
      RESP  = 3'd3,
      FLUSH = 3'd4
   } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from the requester after the last grant and
// moves its pointer only when the grant is actually taken.
module rr_arbiter #(
   parameter int NREQ = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   input  logic            update,
   output logic [NREQ-1:0] grant
);

   localparam int PW = (NREQ > 2) ? 2 : 1;

   logic [PW-1:0] ptr;
   logic [PW-1:0] gidx;
   logic [PW-1:0] idx;

   always_comb begin
      grant = '0;
      gidx  = '0;
      idx   = '0;
      for (int i = 1; i <= NREQ; i++) begin
         idx = PW'((int'(ptr) + i) % NREQ);
         if (grant == '0 && req[idx]) begin
            grant[idx] = 1'b1;
            gidx       = idx;
         end
      end
   end

   // Reset points at the last requester so requester 0 is searched first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= PW'(NREQ - 1);
      end else if (update && |req) begin
         ptr <= gidx;
      end
   end

endmodule

// File: rtl/sqrt_sched.sv
// Single-flight scheduler sharing one iterative sqrt unit among NREQ requesters.
// Define SQRT_SCHED_TIMEOUT_EN to abort operations the unit never finishes.
module sqrt_sched
   import sqrt_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 15
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*OP_W-1:0] req_op,
   output logic [NREQ-1:0]      req_ready,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [1:0]           rsp_id,
   output logic [RES_W-1:0]     rsp_data,
   output logic [FLG_W-1:0]     rsp_flags,
   output logic                 it_enable,
   output logic                 it_n_valid,
   output logic [OP_W-1:0]      it_op,
   input  logic                 it_valid,
   input  logic                 it_result,
   input  logic [RES_W-1:0]     it_res,
   input  logic [2:0]           it_flags
);

   sched_state_t    state;
   sched_state_t    state_nxt;
   logic            en_q;
   logic            take;
   logic            to_hit;
   logic [NREQ-1:0] grant;
   logic [1:0]      gidx;
   logic [OP_W-1:0] op_sel;

   // en_q keeps every handshake quiet until the first edge after reset.
   assign take       = (state == IDLE) && en_q && (|req_valid);
   assign req_ready  = take ? grant : '0;
   assign it_n_valid = (state == ISSUE);
   assign rsp_valid  = (state == RESP);
   assign it_enable  = en_q && (state != FLUSH);

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req_valid),
      .update (take),
      .grant  (grant)
   );

   always_comb begin
      gidx   = '0;
      op_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            gidx   = 2'(i);
            op_sel = req_op[i*OP_W +: OP_W];
         end
      end
   end

`ifdef SQRT_SCHED_TIMEOUT_EN
   logic [7:0] to_cnt;
   logic       unused_inputs;

   assign unused_inputs = it_valid;
   assign to_hit        = (to_cnt >= 8'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt <= '0;
      end else if (state == ISSUE) begin
         to_cnt <= '0;
      end else if (state == BUSY && to_cnt != 8'hff) begin
         to_cnt <= to_cnt + 8'd1;
      end
   end
`else
   logic unused_inputs;

   assign unused_inputs = ^{it_valid, 8'(TIMEOUT)};
   assign to_hit        = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q  <= 1'b0;
         state <= IDLE;
      end else begin
         en_q  <= 1'b1;
         state <= state_nxt;
      end
   end

   // A unit strobe in the expiry cycle still counts as a normal result.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (take) state_nxt = ISSUE;
         ISSUE:   state_nxt = BUSY;
         BUSY: begin
            if (it_result)   state_nxt = RESP;
            else if (to_hit) state_nxt = FLUSH;
         end
         FLUSH:   state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         it_op     <= '0;
         rsp_id    <= '0;
         rsp_data  <= '0;
         rsp_flags <= '0;
      end else begin
         if (take) begin
            it_op  <= op_sel;
            rsp_id <= gidx;
         end
         if (state == BUSY && it_result) begin
            rsp_data  <= it_res;
            rsp_flags <= {it_flags, 1'b0};
         end
`ifdef SQRT_SCHED_TIMEOUT_EN
         else if (state == FLUSH) begin
            rsp_data  <= '0;
            rsp_flags <= 4'b0001;
         end
`endif
      end
   end

endmodule

// File: tb/tb_sqrt_sched.sv
// Bench for sqrt_sched: stand-in sqrt unit, transaction-level reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_sqrt_sched;
   import sqrt_pkg::*;

   localparam int NREQ    = 2;
   localparam int TIMEOUT = 15;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [NREQ-1:0]      req_valid = '0;
   logic [NREQ*OP_W-1:0] req_op = '0;
   logic [NREQ-1:0]      req_ready;
   logic                 rsp_valid;
   logic                 rsp_ready = 1'b1;
   logic [1:0]           rsp_id;
   logic [RES_W-1:0]     rsp_data;
   logic [FLG_W-1:0]     rsp_flags;
   logic                 it_enable;
   logic                 it_n_valid;
   logic [OP_W-1:0]      it_op;
   logic                 it_valid = 1'b0;
   logic                 it_result = 1'b0;
   logic [RES_W-1:0]     it_res = '0;
   logic [2:0]           it_flags = '0;

   always #5 clk = ~clk;

   sqrt_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_op     (req_op),
      .req_ready  (req_ready),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_data   (rsp_data),
      .rsp_flags  (rsp_flags),
      .it_enable  (it_enable),
      .it_n_valid (it_n_valid),
      .it_op      (it_op),
      .it_valid   (it_valid),
      .it_result  (it_result),
      .it_res     (it_res),
      .it_flags   (it_flags)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act === exp_v) n_pass++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
   endtask

   function automatic logic [OP_W-1:0] mk_num(input int e, input int m);
      return {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'(e), 11'(m)};
   endfunction

   // Reference sqrt: value = 1.mant * 2^exp, exp signed.
   function automatic logic [21:0] unit_calc(input logic [OP_W-1:0] op);
      int     e;
      longint x;
      longint r;
      if (op[OP_NAN] || op[OP_NINF] || (op[OP_NUM] && op[18])) return {3'b100, NAN_RES};
      if (op[OP_PINF]) return {3'b010, 19'd0};
      if (!op[OP_NUM]) return {3'b000, 19'd0};
      e = int'($signed(op[17:11]));
      x = 2048 + op[10:0];
      if (e % 2 != 0) begin
         x = x * 2;
         e = e - 1;
      end
      x = x * 2048;
      r = 0;
      while ((r + 1) * (r + 1) <= x) r++;
      return {3'b000, 1'b0, 7'(e / 2), 11'(r - 2048)};
   endfunction

   // Stand-in sqrt unit: specials answer one cycle after the strobe.
   logic        stub = 1'b0;
   logic        spur = 1'b0;
   int          lat = 3;
   int          u_cnt = 0;
   logic        u_fire = 1'b0;
   logic        u_clear = 1'b0;
   logic [21:0] u_out = '0;

   always @(negedge clk) begin
      u_fire  = it_n_valid && !stub;
      u_clear = !it_enable;
   end

   always @(posedge clk) begin
      #1;
      it_result = 1'b0;
      it_valid  = 1'($urandom_range(0, 1));
      if (u_clear) u_cnt = 0;
      if (u_fire) begin
         u_out = unit_calc(it_op);
         u_cnt = (it_op[OP_NAN] || it_op[OP_PINF] || it_op[OP_NINF] || !it_op[OP_NUM]) ? 1 : lat;
      end
      if (u_cnt > 0) begin
         u_cnt--;
         if (u_cnt == 0) begin
            it_result = 1'b1;
            it_res    = u_out[18:0];
            it_flags  = u_out[21:19];
         end
      end
      if (spur) begin
         it_result = 1'b1;
         it_res    = 19'h7ffff;
         it_flags  = 3'b111;
      end
   end

   // Reference model: one operation in flight, tracked by age since grant.
   int               m_ptr = NREQ - 1;
   int               m_id = 0;
   int               m_age = 0;
   logic             m_en = 1'b0;
   logic             m_inflight = 1'b0;
   logic             m_has_rsp = 1'b0;
   logic             m_flush = 1'b0;
   logic [OP_W-1:0]  m_itop = '0;
   logic [RES_W-1:0] m_rdata = '0;
   logic [3:0]       m_rflags = '0;
   int               grant_log[$];
   int               t_issue = 0;
   int               t_flush = 0;
   int               n_low = 0;
   logic             count_low = 1'b0;

   function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] v);
      for (int i = 1; i <= NREQ; i++) begin
         int k;
         k = (ptr + i) % NREQ;
         if (v[k]) return k;
      end
      return -1;
   endfunction

   always @(negedge clk) begin : cmp
      int              g;
      logic [NREQ-1:0] exp_ready;
      if (!rst_n) begin
         m_en = 1'b0; m_inflight = 1'b0; m_has_rsp = 1'b0; m_flush = 1'b0;
         m_ptr = NREQ - 1; m_id = 0; m_age = 0;
         m_itop = '0; m_rdata = '0; m_rflags = '0;
      end
      g = rr_pick(m_ptr, req_valid);
      exp_ready = '0;
      if (m_en && !m_inflight && g >= 0) exp_ready[g] = 1'b1;
      check_output("req_ready", 32'(req_ready), 32'(exp_ready));
      check_output("it_enable", 32'(it_enable), 32'(m_en && !m_flush));
      check_output("it_n_valid", 32'(it_n_valid), 32'(m_inflight && !m_has_rsp && m_age == 1));
      check_output("rsp_valid", 32'(rsp_valid), 32'(m_has_rsp));
      if (!rst_n || m_has_rsp) begin
         check_output("rsp_data", 32'(rsp_data), 32'(m_rdata));
         check_output("rsp_flags", 32'(rsp_flags), 32'(m_rflags));
         check_output("rsp_id", 32'(rsp_id), 32'(m_id));
      end
      if (!rst_n || (m_inflight && !m_has_rsp)) check_output("it_op", 32'(it_op), 32'(m_itop));

      for (int i = 0; i < NREQ; i++) if (req_ready[i]) grant_log.push_back(i);
      if (it_n_valid) t_issue = cyc;
      if (count_low && rst_n && !it_enable) begin
         n_low++;
         t_flush = cyc;
      end

      if (rst_n) begin
         if (!m_inflight) begin
            if (m_en && g >= 0) begin
               m_inflight = 1'b1; m_ptr = g; m_id = g; m_age = 1;
               m_itop = req_op[g*OP_W +: OP_W];
            end
         end else if (m_has_rsp) begin
            if (rsp_ready) begin
               m_inflight = 1'b0;
               m_has_rsp  = 1'b0;
            end
         end else if (m_flush) begin
            m_flush = 1'b0; m_has_rsp = 1'b1; m_rdata = '0; m_rflags = 4'b0001;
         end else if (m_age == 1) begin
            m_age = 2;
         end else begin
            if (it_result) begin
               m_has_rsp = 1'b1; m_rdata = it_res; m_rflags = {it_flags, 1'b0};
            end
`ifdef SQRT_SCHED_TIMEOUT_EN
            else if (m_age - 1 >= TIMEOUT) begin
               m_flush = 1'b1;
            end
`endif
            m_age++;
         end
         m_en = 1'b1;
      end
   end

   task automatic apply_stimulus(input int idx, input logic [OP_W-1:0] op, output int waited);
      @(posedge clk);
      #1;
      req_valid[idx]             = 1'b1;
      req_op[idx*OP_W +: OP_W]   = op;
      waited = 0;
      forever begin
         @(negedge clk);
         if (req_ready[idx]) break;
         waited++;
         if (waited > 100) begin
            check_output("grant_wait", 32'(req_ready[idx]), 32'd1);
            break;
         end
      end
      @(posedge clk);
      #1;
      req_valid[idx] = 1'b0;
   endtask

   task automatic wait_rsp(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (rsp_valid) return;
      end
      check_output("rsp_wait", 32'(rsp_valid), 32'd1);
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int w;
      int exp_order[4];
      logic [OP_W-1:0] op_4, op_9, op_16, op_ninf;
      exp_order = '{0, 1, 0, 1};
      op_4    = mk_num(2, 0);
      op_9    = mk_num(3, 256);
      op_16   = mk_num(4, 0);
      op_ninf = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 7'd0, 11'd0};

      // Reset with both requesters asserting: nothing may be granted.
      req_valid = 2'b11;
      repeat (3) @(negedge clk);
      check_output("rst_req_ready", 32'(req_ready), 32'd0);
      check_output("rst_it_enable", 32'(it_enable), 32'd0);
      check_output("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_output("rst_it_op", 32'(it_op), 32'd0);
      @(posedge clk);
      #1;
      req_valid = '0;
      rst_n     = 1'b1;

      // 4.0 from requester 0.
      lat = 3;
      apply_stimulus(0, op_4, w);
      check_output("a_same_cycle_grant", 32'(w), 32'd0);
      wait_rsp(50);
      check_output("a_rsp_data", 32'(rsp_data), 32'h00800);
      check_output("a_rsp_id", 32'(rsp_id), 32'd0);
      check_output("a_rsp_flags", 32'(rsp_flags), 32'd0);

      // Negative infinity from requester 1 yields the NaN result.
      apply_stimulus(1, op_ninf, w);
      wait_rsp(50);
      check_output("c_rsp_flags", 32'(rsp_flags), 32'h8);
      check_output("c_rsp_data", 32'(rsp_data), 32'h48400);
      check_output("c_rsp_id", 32'(rsp_id), 32'd1);

      // Both requesters continuously valid: alternating grants.
      lat = 2;
      grant_log.delete();
      @(posedge clk);
      #1;
      req_op    = {op_16, op_4};
      req_valid = 2'b11;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         if (grant_log.size() >= 4) break;
      end
      #1;
      req_valid = '0;
      check_output("b_grant_count", 32'(grant_log.size()), 32'd4);
      for (int i = 0; i < 4 && i < grant_log.size(); i++)
         check_output("b_grant_order", 32'(grant_log[i]), 32'(exp_order[i]));
      wait_rsp(50);
      check_output("b_last_rsp_data", 32'(rsp_data), 32'h01000);

      // Backpressure: response held for 10 cycles, stray unit strobe ignored.
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      apply_stimulus(0, op_9, w);
      wait_rsp(50);
      @(posedge clk);
      #1;
      req_op[OP_W +: OP_W] = op_4;
      req_valid[1]         = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #2;
         spur = (i == 2);
         @(negedge clk);
         check_output("d_hold_valid", 32'(rsp_valid), 32'd1);
         check_output("d_hold_data", 32'(rsp_data), 32'h00c00);
         check_output("d_hold_ready", 32'(req_ready), 32'd0);
      end
      spur = 1'b0;
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (req_ready[1]) break;
      end
      check_output("d_next_grant", 32'(req_ready), 32'h2);
      @(posedge clk);
      #1;
      req_valid[1] = 1'b0;
      wait_rsp(50);
      check_output("d_rsp_data", 32'(rsp_data), 32'h00800);
      check_output("d_rsp_id", 32'(rsp_id), 32'd1);

      // Unit never answers.
      stub      = 1'b1;
      n_low     = 0;
      count_low = 1'b1;
      apply_stimulus(0, op_4, w);
`ifdef SQRT_SCHED_TIMEOUT_EN
      wait_rsp(100);
      check_output("e_rsp_flags", 32'(rsp_flags), 32'h1);
      check_output("e_rsp_data", 32'(rsp_data), 32'd0);
      check_output("e_flush_cycles", 32'(n_low), 32'd1);
      check_output("e_busy_span", 32'(t_flush - t_issue), 32'd16);
      count_low = 1'b0;
      apply_stimulus(1, op_16, w);
`else
      repeat (60) @(negedge clk);
      check_output("e_still_busy", 32'(rsp_valid), 32'd0);
      check_output("e_enable_high", 32'(it_enable), 32'd1);
      check_output("e_no_flush", 32'(n_low), 32'd0);
      count_low = 1'b0;
`endif

      // Asynchronous reset in the middle of BUSY.
      repeat (3) @(posedge clk);
      #3;
      req_valid = 2'b01;
      rst_n     = 1'b0;
      #1;
      check_output("f_rsp_valid", 32'(rsp_valid), 32'd0);
      check_output("f_req_ready", 32'(req_ready), 32'd0);
      check_output("f_it_enable", 32'(it_enable), 32'd0);
      check_output("f_it_n_valid", 32'(it_n_valid), 32'd0);
      check_output("f_it_op", 32'(it_op), 32'd0);
      check_output("f_rsp_data", 32'(rsp_data), 32'd0);
      check_output("f_rsp_flags", 32'(rsp_flags), 32'd0);
      check_output("f_rsp_id", 32'(rsp_id), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      req_valid = '0;
      stub      = 1'b0;
      rst_n     = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check_output("f_no_stale_rsp", 32'(rsp_valid), 32'd0);

      apply_stimulus(1, op_16, w);
      check_output("f_recover_grant", 32'(w), 32'd0);
      wait_rsp(50);
      check_output("f_recover_data", 32'(rsp_data), 32'h01000);
      check_output("f_recover_id", 32'(rsp_id), 32'd1);
      repeat (3) @(posedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
